// File: rtl/console_uart_rx.sv
// console_uart_rx: 8N1 UART receiver feeding a first-word fall-through byte FIFO
// with sticky frame-error and overrun flags.
module console_uart_rx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 16,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          rx,
  output logic [7:0]                    in_byte,
  output logic                          in_byte_valid,
  input  logic                          in_byte_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          frame_err,
  output logic                          overrun,
  input  logic                          err_clear
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [2:0] S_IDLE = 3'd0, S_START = 3'd1, S_DATA = 3'd2, S_STOP = 3'd3, S_BREAK = 3'd4;
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  logic [SYNC_STAGES-1:0] r_sync;
  logic [2:0]             r_state;
  logic [CW-1:0]          r_cnt;
  logic [2:0]             r_bit;
  logic [7:0]             r_shift;
  logic                   r_push;
  logic [7:0]             r_mem [FIFO_DEPTH];
  logic [AW-1:0]          r_wr, r_rd;
  logic [AW:0]            r_count;
  logic                   r_frame_err, r_overrun;
  logic                   w_rx_s, w_full, w_pop, w_wr, w_ovr, w_stop_bad;
  assign w_rx_s        = r_sync[SYNC_STAGES-1];
  assign w_full        = r_count == (AW+1)'(FIFO_DEPTH);
  assign in_byte_valid = r_count != '0;
  assign w_pop         = in_byte_valid && in_byte_ready;
  assign w_wr          = r_push && (!w_full || w_pop);
  assign w_ovr         = r_push && w_full && !w_pop;
  assign w_stop_bad    = r_state == S_STOP && r_cnt == FULL && !w_rx_s;
  assign in_byte       = r_mem[r_rd];
  assign fifo_count    = r_count;
  assign frame_err     = r_frame_err;
  assign overrun       = r_overrun;
  always_ff @(posedge clk) begin
    if (reset) r_sync <= '1;
    else r_sync <= {r_sync[SYNC_STAGES-2:0], rx};
  end
  // Byte is latched at the stop-bit sample and pushed on the following cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_push  <= 1'b0;
    end else begin
      r_push <= 1'b0;
      r_cnt  <= r_cnt + CW'(1);
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (!w_rx_s) r_state <= S_START;
        end
        S_START: if (r_cnt == HALF) begin
          r_cnt   <= '0;
          r_bit   <= '0;
          r_state <= w_rx_s ? S_IDLE : S_DATA;
        end
        S_DATA: if (r_cnt == FULL) begin
          r_cnt   <= '0;
          r_shift <= {w_rx_s, r_shift[7:1]};
          r_bit   <= r_bit + 3'd1;
          if (r_bit == 3'd7) r_state <= S_STOP;
        end
        S_STOP: if (r_cnt == FULL) begin
          r_cnt   <= '0;
          r_push  <= w_rx_s;
          r_state <= w_rx_s ? S_IDLE : S_BREAK;
        end
        S_BREAK: begin
          r_cnt <= '0;
          if (w_rx_s) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) begin
        r_mem[r_wr] <= r_shift;
        r_wr        <= r_wr + AW'(1);
      end
      if (w_pop) r_rd <= r_rd + AW'(1);
      r_count <= r_count + (AW+1)'(w_wr) - (AW+1)'(w_pop);
    end
  end
  // A new error in the same cycle as err_clear keeps the flag set.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= w_stop_bad ? 1'b1 : err_clear ? 1'b0 : r_frame_err;
      r_overrun   <= w_ovr ? 1'b1 : err_clear ? 1'b0 : r_overrun;
    end
  end
endmodule

// File: tb/tb_console_uart_rx.sv
// tb_console_uart_rx: directed frames against a queue-based receiver/FIFO model,
// compared every cycle, plus literal expectations per scenario.
module tb_console_uart_rx;
  localparam int CPB   = 8;
  localparam int DEPTH = 16;
  localparam int LAT   = 80;
  logic       clk = 1'b0, reset = 1'b1, rx = 1'b1, in_byte_ready = 1'b0, err_clear = 1'b0;
  logic [7:0] in_byte;
  logic       in_byte_valid, frame_err, overrun;
  logic [4:0] fifo_count;
  console_uart_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .rx(rx), .in_byte(in_byte), .in_byte_valid(in_byte_valid),
    .in_byte_ready(in_byte_ready), .fifo_count(fifo_count), .frame_err(frame_err),
    .overrun(overrun), .err_clear(err_clear)
  );
  always #5 clk = ~clk;
  int         checks = 0, errors = 0, cyc = 0;
  logic [7:0] mq[$];
  bit         m_ferr = 1'b0, m_ovr = 1'b0, started = 1'b0;
  logic [7:0] ev_push[int];
  bit         ev_ferr[int];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  // Model: a good frame lands LAT cycles after its start edge, a bad stop flags one cycle earlier.
  always @(posedge clk) begin : model
    bit pop, fe, ov;
    cyc++;
    if (reset) begin
      mq.delete();
      m_ferr = 1'b0;
      m_ovr  = 1'b0;
      ev_push.delete();
      ev_ferr.delete();
    end else begin
      pop = mq.size() != 0 && in_byte_ready;
      fe  = ev_ferr.exists(cyc);
      ov  = 1'b0;
      if (pop) void'(mq.pop_front());
      if (ev_push.exists(cyc)) begin
        if (mq.size() < DEPTH) mq.push_back(ev_push[cyc]);
        else ov = 1'b1;
      end
      m_ferr = fe ? 1'b1 : err_clear ? 1'b0 : m_ferr;
      m_ovr  = ov ? 1'b1 : err_clear ? 1'b0 : m_ovr;
    end
    started = 1'b1;
  end
  always @(negedge clk) if (started) begin
    chk("valid", 32'(in_byte_valid), 32'(mq.size() != 0));
    chk("count", 32'(fifo_count), 32'(mq.size()));
    if (mq.size() != 0) chk("head", 32'(in_byte), 32'(mq[0]));
    chk("frame_err", 32'(frame_err), 32'(m_ferr));
    chk("overrun", 32'(overrun), 32'(m_ovr));
  end
  task automatic idle(input int k);
    repeat (k) @(negedge clk);
  endtask
  task automatic send(input logic [7:0] b, input bit ok, input int stop_len);
    int n = cyc;
    if (ok) ev_push[n+LAT] = b;
    else ev_ferr[n+LAT-1] = 1'b1;
    rx = 1'b0;
    idle(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      idle(CPB);
    end
    rx = ok;
    idle(stop_len);
    rx = 1'b1;
  endtask
  task automatic drain();
    in_byte_ready = 1'b1;
    idle(DEPTH + 1);
    in_byte_ready = 1'b0;
  endtask
  initial begin
    logic [7:0] pb;
    pb = 8'h81;
    @(negedge clk);
    chk("rst_valid", 32'(in_byte_valid), 0);
    chk("rst_count", 32'(fifo_count), 0);
    chk("rst_byte", 32'(in_byte), 0);
    idle(2);
    reset = 1'b0;
    idle(4);
    send(8'h48, 1'b1, 7);
    chk("t1_early_valid", 32'(in_byte_valid), 0);
    idle(1);
    chk("t1_byte", 32'(in_byte), 32'h48);
    chk("t1_valid", 32'(in_byte_valid), 1);
    chk("t1_count", 32'(fifo_count), 1);
    chk("t1_ferr", 32'(frame_err), 0);
    drain();
    send(8'h48, 1'b1, 8);
    send(8'h69, 1'b1, 8);
    send(8'h0A, 1'b1, 8);
    idle(2);
    chk("t2_count", 32'(fifo_count), 3);
    in_byte_ready = 1'b1;
    chk("t2_b0", 32'(in_byte), 32'h48);
    idle(1);
    chk("t2_b1", 32'(in_byte), 32'h69);
    idle(1);
    chk("t2_b2", 32'(in_byte), 32'h0A);
    idle(1);
    chk("t2_empty", 32'(in_byte_valid), 0);
    in_byte_ready = 1'b0;
    rx = 1'b0;
    idle(2);
    rx = 1'b1;
    idle(20);
    chk("t3_count", 32'(fifo_count), 0);
    chk("t3_ferr", 32'(frame_err), 0);
    send(8'h55, 1'b1, 8);
    idle(2);
    chk("t3_byte", 32'(in_byte), 32'h55);
    chk("t3_count1", 32'(fifo_count), 1);
    drain();
    send(8'hA5, 1'b0, 40);
    chk("t4_ferr", 32'(frame_err), 1);
    chk("t4_count", 32'(fifo_count), 0);
    idle(10);
    send(8'h3C, 1'b1, 8);
    idle(2);
    chk("t4_byte", 32'(in_byte), 32'h3C);
    chk("t4_ferr_held", 32'(frame_err), 1);
    err_clear = 1'b1;
    idle(1);
    err_clear = 1'b0;
    chk("t4_ferr_clr", 32'(frame_err), 0);
    drain();
    for (int i = 0; i < 17; i++) send(8'(i), 1'b1, 8);
    idle(2);
    chk("t5_count", 32'(fifo_count), 16);
    chk("t5_ovr", 32'(overrun), 1);
    chk("t5_head", 32'(in_byte), 0);
    in_byte_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("t5_drain", 32'(in_byte), 32'(i));
      idle(1);
    end
    in_byte_ready = 1'b0;
    chk("t5_empty", 32'(in_byte_valid), 0);
    err_clear = 1'b1;
    idle(1);
    err_clear = 1'b0;
    for (int i = 0; i < 16; i++) send(8'(8'h20 + i), 1'b1, 8);
    fork
      send(8'h30, 1'b1, 8);
      begin
        idle(LAT - 1);
        in_byte_ready = 1'b1;
        idle(1);
        in_byte_ready = 1'b0;
      end
    join
    idle(2);
    chk("t5b_count", 32'(fifo_count), 16);
    chk("t5b_ovr", 32'(overrun), 0);
    chk("t5b_head", 32'(in_byte), 32'h21);
    rx = 1'b0;
    idle(CPB);
    for (int i = 0; i < 3; i++) begin
      rx = pb[i];
      idle(CPB);
    end
    rx = pb[3];
    idle(CPB / 2);
    reset = 1'b1;
    rx = 1'b1;
    idle(2);
    reset = 1'b0;
    idle(1);
    chk("t6_valid", 32'(in_byte_valid), 0);
    chk("t6_count", 32'(fifo_count), 0);
    chk("t6_ferr", 32'(frame_err), 0);
    chk("t6_ovr", 32'(overrun), 0);
    chk("t6_byte", 32'(in_byte), 0);
    idle(5);
    send(8'h7E, 1'b1, 8);
    idle(2);
    chk("t6_rx", 32'(in_byte), 32'h7E);
    chk("t6_count1", 32'(fifo_count), 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
